// File: rtl/m8_frame_serializer.sv
// -----------------------------------------------------------------------------
// m8_frame_serializer
//
// Pulls 12-bit words from a frame filler (1024 words per frame) and sends them
// as a continuous NRZ bit stream, MSB first, one bit every BIT_DIV clocks.
// The next word is prefetched during the last bit of the current one, so the
// stream has no gaps across word boundaries. Dropping enable stops the stream
// cleanly at the end of the word in flight.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   enable       in   1 = transmit continuously, 0 = stop at next word boundary
//   bufGetWord   out  one-cycle word request strobe to the filler
//   bufRdPointer out  index of the requested word (valid with bufGetWord)
//   dataWord     in   filler word, valid the cycle after bufGetWord
//   serOut       out  serial data, MSB first
//   bitStrobe    out  one-cycle pulse on the first clock of every bit
//   frameStart   out  one-cycle pulse on the first clock of word 0's MSB
//   busy         out  high whenever the serializer is not idle
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module m8_frame_serializer #(
  parameter int unsigned BIT_DIV   = 8,   // clocks per serial bit, 3..255
  parameter int unsigned WORD_BITS = 12   // serial word width (fixed at 12)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 bufGetWord,
  output logic [9:0]           bufRdPointer,
  input  logic [WORD_BITS-1:0] dataWord,
  output logic                 serOut,
  output logic                 bitStrobe,
  output logic                 frameStart,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  localparam logic [7:0] TIMER_LAST = 8'(BIT_DIV - 1);
  localparam logic [3:0] BIT_FIRST  = 4'(WORD_BITS - 1);

  state_e               state_q,     state_d;
  logic [9:0]           ptr_q,       ptr_d;
  logic [WORD_BITS-1:0] shift_q,     shift_d;
  logic [WORD_BITS-1:0] hold_q,      hold_d;
  logic                 hold_ptr0_q, hold_ptr0_d;  // prefetched word is word 0
  logic                 cur_ptr0_q,  cur_ptr0_d;   // word on the wire is word 0
  logic [7:0]           timer_q,     timer_d;
  logic [3:0]           bitcnt_q,    bitcnt_d;

  logic get_q,    get_d;
  logic ser_q,    ser_d;
  logic strobe_q, strobe_d;
  logic frame_q,  frame_d;
  logic busy_q,   busy_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_ptr0_d = hold_ptr0_q;
    cur_ptr0_d  = cur_ptr0_q;
    timer_d     = timer_q;
    bitcnt_d    = bitcnt_q;

    case (state_q)
      ST_IDLE: begin
        ptr_d    = 10'd0;
        timer_d  = 8'd0;
        bitcnt_d = 4'd0;
        if (enable) state_d = ST_FETCH;
      end

      // Request word 0; the filler answers on the following (LOAD) cycle.
      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        shift_d    = dataWord;
        ptr_d      = 10'd1;
        cur_ptr0_d = 1'b1;
        bitcnt_d   = BIT_FIRST;
        timer_d    = 8'd0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        timer_d = timer_q + 8'd1;

        // Prefetch during the last bit: the request goes out at timer 0,
        // the answer is captured at timer 1, well before the reload.
        if (bitcnt_q == 4'd0 && timer_q == 8'd0) begin
          ptr_d       = ptr_q + 10'd1;      // wraps 1023 -> 0
          hold_ptr0_d = (ptr_q == 10'd0);
        end
        if (bitcnt_q == 4'd0 && timer_q == 8'd1) hold_d = dataWord;

        if (timer_q == TIMER_LAST) begin
          timer_d = 8'd0;
          if (bitcnt_q != 4'd0) begin
            shift_d  = {shift_q[WORD_BITS-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 4'd1;
          end else if (enable) begin
            // Back-to-back reload keeps the bit timing seamless.
            shift_d    = hold_q;
            cur_ptr0_d = hold_ptr0_q;
            bitcnt_d   = BIT_FIRST;
          end else begin
            // Stop: the prefetched word is dropped and the frame restarts at 0.
            state_d  = ST_IDLE;
            ptr_d    = 10'd0;
            bitcnt_d = 4'd0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, so they line
  // up with the state they describe without a combinational output path.
  always_comb begin
    get_d    = (state_d == ST_FETCH) ||
               (state_d == ST_SHIFT && bitcnt_d == 4'd0 && timer_d == 8'd0);
    ser_d    = (state_d == ST_SHIFT) && shift_d[WORD_BITS-1];
    strobe_d = (state_d == ST_SHIFT) && (timer_d == 8'd0);
    frame_d  = strobe_d && (bitcnt_d == BIT_FIRST) && cur_ptr0_d;
    busy_d   = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the data registers (shift/hold) are reset along with the control
  // state so that an aborted word can never leak into the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 10'd0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_ptr0_q <= 1'b0;
      cur_ptr0_q  <= 1'b0;
      timer_q     <= 8'd0;
      bitcnt_q    <= 4'd0;
      get_q       <= 1'b0;
      ser_q       <= 1'b0;
      strobe_q    <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_ptr0_q <= hold_ptr0_d;
      cur_ptr0_q  <= cur_ptr0_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      get_q       <= get_d;
      ser_q       <= ser_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
    end
  end

  assign bufGetWord   = get_q;
  assign bufRdPointer = ptr_q;
  assign serOut       = ser_q;
  assign bitStrobe    = strobe_q;
  assign frameStart   = frame_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_m8_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_m8_frame_serializer
//
// Two serializer instances (BIT_DIV=8 and BIT_DIV=3) each fed by a filler
// model whose word depends on the requested pointer. A scoreboard queue
// receives the expected word on every request; a monitor rebuilds words from
// the serial line and pops/compares them, and also checks pointer sequence,
// bit timing, frameStart placement and clean stopping. Directed steps run in
// one initial block; only one instance is active at a time.
// -----------------------------------------------------------------------------
module tb_m8_frame_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // BIT_DIV = 8 instance
  logic        rst8, en8, get8, ser8, stb8, frm8, busy8;
  logic [9:0]  ptr8;
  logic [11:0] dw8;
  // BIT_DIV = 3 instance
  logic        rst3, en3, get3, ser3, stb3, frm3, busy3;
  logic [9:0]  ptr3;
  logic [11:0] dw3;

  m8_frame_serializer #(.BIT_DIV(8), .WORD_BITS(12)) u_dut8 (
    .clk(clk), .reset(rst8), .enable(en8), .bufGetWord(get8),
    .bufRdPointer(ptr8), .dataWord(dw8), .serOut(ser8), .bitStrobe(stb8),
    .frameStart(frm8), .busy(busy8)
  );

  m8_frame_serializer #(.BIT_DIV(3), .WORD_BITS(12)) u_dut3 (
    .clk(clk), .reset(rst3), .enable(en3), .bufGetWord(get3),
    .bufRdPointer(ptr3), .dataWord(dw3), .serOut(ser3), .bitStrobe(stb3),
    .frameStart(frm3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Filler contents: word 0 is the known pattern, the rest are pointer-derived.
  function automatic logic [11:0] word_of(input logic [9:0] p);
    return (p == 10'd0) ? 12'hA5C : ({p, 2'b11} ^ 12'h6C9);
  endfunction

  // Filler stubs: answer on the cycle after a request, junk otherwise.
  always @(posedge clk) dw8 <= get8 ? word_of(ptr8) : 12'($urandom);
  always @(posedge clk) dw3 <= get3 ? word_of(ptr3) : 12'($urandom);

  // ---------------------------------------------------------------------------
  // Scoreboard + monitor on the active instance
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [11:0] word;
    logic        ptr0;
  } item_t;

  item_t exp_q[$];

  logic       use3;
  logic       m_rst, m_get, m_ser, m_stb, m_frm, m_busy;
  logic [9:0] m_ptr;
  int         m_div;
  assign m_rst  = use3 ? rst3  : rst8;
  assign m_get  = use3 ? get3  : get8;
  assign m_ser  = use3 ? ser3  : ser8;
  assign m_stb  = use3 ? stb3  : stb8;
  assign m_frm  = use3 ? frm3  : frm8;
  assign m_busy = use3 ? busy3 : busy8;
  assign m_ptr  = use3 ? ptr3  : ptr8;
  assign m_div  = use3 ? 3 : 8;

  logic [9:0]  exp_ptr;
  logic [11:0] acc;
  logic        prev_get, prev_busy, have_prev, held;
  int          nbits, since, words = 0, gets = 0, frames = 0, first_frame = 0;
  item_t       it;

  always @(negedge clk) begin
    if (!m_rst) begin
      exp_q.delete();
      nbits = 0; since = 0; exp_ptr = 10'd0;
      prev_get = 1'b0; prev_busy = 1'b0; have_prev = 1'b0;
    end else begin
      check("frame_without_strobe", 32'(m_frm & ~m_stb), 0);

      if (m_get) begin
        gets++;
        check("get_back_to_back", 32'(prev_get), 0);
        check("request_pointer", 32'(m_ptr), 32'(exp_ptr));
        it.word = word_of(exp_ptr);
        it.ptr0 = (exp_ptr == 10'd0);
        exp_q.push_back(it);
        exp_ptr = exp_ptr + 10'd1;
      end

      if (m_stb) begin
        if (have_prev) check("bit_period", 32'(since), 32'(m_div));
        have_prev = 1'b1; since = 1; held = m_ser;
        if (nbits == 0) begin
          check("word_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("frame_start", 32'(m_frm), 32'(exp_q[0].ptr0));
          if (m_frm && use3) begin
            if (frames == 1) check("frame_interval", 32'(cyc - first_frame), 1024 * 12 * 3);
            if (frames == 0) first_frame = cyc;
            frames++;
          end
        end
        acc = {acc[10:0], m_ser};
        nbits++;
        if (nbits == 12) begin
          if (exp_q.size() > 0) begin
            check("word_data", 32'(acc), 32'(exp_q[0].word));
            void'(exp_q.pop_front());
          end
          nbits = 0;
          words++;
        end
      end else if (m_busy && have_prev) begin
        check("bit_hold", 32'(m_ser), 32'(held));
        since++;
      end

      if (prev_busy && !m_busy) begin
        check("stop_on_boundary", 32'(nbits), 0);
        check("prefetch_discarded", 32'(exp_q.size()), 1);
        check("idle_pointer", 32'(m_ptr), 0);
        exp_q.delete();
        have_prev = 1'b0; nbits = 0; exp_ptr = 10'd0;
      end

      prev_get  = m_get;
      prev_busy = m_busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [14:0] outs8;
  assign outs8 = {get8, ptr8, ser8, stb8, frm8, busy8};

  int          n, base, g;
  logic [11:0] pattern;

  initial begin
    rst8 = 1'b1; en8 = 1'b0;
    rst3 = 1'b0; en3 = 1'b0;
    use3 = 1'b0;

    // Reset takes effect without a clock edge; then 100 idle clocks.
    #3 rst8 = 1'b0;
    #1 check("reset_outputs", 32'(outs8), 0);
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'(outs8), 0);
    end
    check("idle_no_request", 32'(gets), 0);

    // First word: fetch, load, then 0xA5C MSB first, 8 clocks per bit.
    base = words;
    en8  = 1'b1;
    @(negedge clk);
    check("fetch_request", 32'(get8), 1);
    check("fetch_pointer", 32'(ptr8), 0);
    check("fetch_busy", 32'(busy8), 1);
    @(negedge clk);
    check("load_no_request", 32'(get8), 0);
    check("load_no_strobe", 32'(stb8), 0);
    pattern = 12'hA5C;
    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check("first_word_bit", 32'(ser8), 32'(pattern[11-b]));
        check("first_word_strobe", 32'(stb8), 32'(c == 0));
        check("first_word_frame", 32'(frm8), 32'(b == 0 && c == 0));
      end
    end

    // Drop enable inside bit 6 of word 5: word 5 finishes, word 6 never goes.
    repeat (1 + 4 * 96 + 40 + 3) @(negedge clk);
    check("drop_point_busy", 32'(busy8), 1);
    en8 = 1'b0;
    n = 0;
    while (busy8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drop_latency", 32'(n), 53);
    check("words_after_drop", 32'(words - base), 6);
    check("pointer_after_drop", 32'(ptr8), 0);
    check("serout_after_drop", 32'(ser8), 0);
    g = gets;
    repeat (50) @(negedge clk);
    check("no_request_when_idle", 32'(gets - g), 0);

    // Reset in bit 3 of word 2 with enable held: instant clear, restart at 0.
    base = words;
    en8  = 1'b1;
    repeat (261) @(negedge clk);
    check("pre_reset_busy", 32'(busy8), 1);
    check("pre_reset_words", 32'(words - base), 2);
    #2 rst8 = 1'b0;
    #1 check("async_reset_outputs", 32'(outs8), 0);
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    n = 0;
    while (!get8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("restart_latency", 32'(n), 1);
    check("restart_pointer", 32'(ptr8), 0);
    base = words;
    repeat (110) @(negedge clk);
    en8 = 1'b0;
    n = 0;
    while (busy8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("restart_stop_timeout", 32'(n < 200), 1);
    check("restart_words", 32'(words - base), 2);

    // BIT_DIV=3: a full frame plus one word, pointer wrap and frame interval.
    use3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b1;
    base = words;
    g    = gets;
    @(negedge clk);
    en3 = 1'b1;
    repeat (3 + 1024 * 36 + 10) @(negedge clk);
    en3 = 1'b0;
    n = 0;
    while (busy3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_stop_timeout", 32'(n < 100), 1);
    check("frame_words", 32'(words - base), 1025);
    check("frame_requests", 32'(gets - g), 1026);
    check("frame_count", 32'(frames), 2);
    check("frame_pointer_idle", 32'(ptr3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m8_frame_serializer.md
M8_FRAME_SERIALIZER -- requirements
Module: m8_frame_serializer

Interface
REQ-001 Parameter BIT_DIV, default 8: clk cycles per serial bit; legal range 3..255.
REQ-002 Parameter WORD_BITS, default 12: serial word width; fixed at 12 for this build.
REQ-003 reset  input  1  asynchronous, active-low; clock clk.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 enable  input  1  high = transmit frames continuously; low = stop at next word boundary.
REQ-006 bufGetWord  output  1  one-cycle word-request strobe to the frame filler.
REQ-007 bufRdPointer  output  10  index of the word being requested; valid while bufGetWord=1.
REQ-008 dataWord  input  12  filler word; valid on the cycle after bufGetWord=1.
REQ-009 serOut  output  1  NRZ serial data, MSB first.
REQ-010 bitStrobe  output  1  one-cycle pulse on the first clk of every bit period.
REQ-011 frameStart  output  1  one-cycle pulse on the first clk of bit 11 of word 0.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, FETCH, LOAD and SHIFT; any unused encoding SHALL return to IDLE.
REQ-014 IDLE: serOut=0, bufRdPointer=0, bit timer=0; enable=1 -> FETCH.
REQ-015 FETCH (1 cycle): bufGetWord=1 with bufRdPointer=0 -> LOAD.
REQ-016 LOAD (1 cycle): capture dataWord into the shift register, bufRdPointer <= 1 -> SHIFT with bit count 11 and timer 0.
REQ-017 SHIFT: serOut = shift register bit [11]; the timer counts 0..BIT_DIV-1; bitStrobe=1 when timer=0.
REQ-018 On timer=BIT_DIV-1 with bit count >0: shift left one, bit count -1, timer -> 0.
REQ-019 Prefetch: in bit 0 (last bit) at timer=0, bufGetWord=1 with the current bufRdPointer.
REQ-020 Prefetch: in bit 0 at timer=1, capture dataWord into a 12-bit hold register.
REQ-021 Prefetch: after the request cycle, bufRdPointer SHALL increment modulo 1024 (1023 -> 0).
REQ-022 End of word (bit 0, timer=BIT_DIV-1), enable=1: shift register <= hold, bit count -> 11, timer -> 0, with no gap in serOut bit timing.
REQ-023 End of word, enable=0: go to IDLE; the prefetched word is discarded and bufRdPointer is cleared to 0.
REQ-024 enable falling mid-word SHALL NOT truncate the current word; enable rising in SHIFT has no effect.
REQ-025 Exactly one bufGetWord pulse per transmitted word; never on consecutive cycles.
REQ-026 frameStart SHALL fire when a word fetched with pointer 0 begins transmission.
REQ-027 Serial rate = clk/BIT_DIV; one word = 12*BIT_DIV clk; one frame = 1024 words.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset low, immediately (asynchronously): state=IDLE; bufGetWord=0, bufRdPointer=0, serOut=0, bitStrobe=0, frameStart=0, busy=0; shift/hold registers, timer and bit count=0.
REQ-030 Reset asserted mid-word SHALL abort transmission; after release, the next frame starts at pointer 0.

Verification
REQ-031 Reset applied, enable=0 for 100 clk -> all outputs 0, no bufGetWord.
REQ-032 BIT_DIV=8, filler stub returning 12'hA5C for pointer 0; enable=1 -> bufGetWord at cycle 1 with pointer 0; serOut=1,0,1,0,0,1,0,1,1,1,0,0 each held 8 clk; frameStart and bitStrobe coincide at the first bit.
REQ-033 Run 1025 words -> pointers requested 0..1023 then 0; second frameStart exactly 1024*12*BIT_DIV clk after the first; no bit-period gaps.
REQ-034 enable dropped at bit 6 of word 5 -> word 5 completes, busy falls, bufRdPointer=0, the prefetched word 6 is never sent.
REQ-035 Reset pulsed at bit 3 of word 2, then enable held -> outputs cleared at once; the next bufGetWord carries pointer 0.
REQ-036 BIT_DIV=3 -> hold capture and reload still occur with continuous 3-clk bits across word boundaries.
